// File: rtl/sar_search_pkg.sv
// Shared types and constants for the successive-approximation search engine.
package sar_search_pkg;

  localparam int SAR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/sar_search.sv
// Binary search that recovers a hidden operand from an external greater-than flag.
// Optional abort port and early exit enabled with `define SAR_SEARCH_ABORT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// SEARCH | resolving one bit per cycle, MSB first
// DONE   | result valid, done pulses for one cycle
module sar_search
  import sar_search_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gt_in,
`ifdef SAR_SEARCH_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] new_acc;
  logic [WIDTH-1:0] next_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      guess_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      guess_q  <= guess_d;
      result_q <= result_d;
    end
  end

  // The comparator asks target > guess; presenting trial-1 turns that into target >= trial.
  always_comb begin
    trial    = acc_q | (ONE << idx_q);
    new_acc  = gt_in ? trial : acc_q;
    next_bit = ONE << (idx_q - IW'(1));
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    guess_d  = guess_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEARCH;
          acc_d   = '0;
          idx_d   = IW'(WIDTH - 1);
          guess_d = (ONE << (WIDTH - 1)) - ONE;
        end
      end
      SEARCH: begin
        acc_d = new_acc;
        if (idx_q == '0) begin
          state_d  = DONE;
          result_d = new_acc;
        end else begin
          idx_d   = idx_q - IW'(1);
          guess_d = (new_acc | next_bit) - ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef SAR_SEARCH_ABORT_EN
    // Abort wins over completion so a cancelled search never publishes a result.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      result_d = result_q;
    end
`endif
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign busy   = (state_q == SEARCH);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search; a greater-than comparator closes the loop to a hidden target.
module tb_sar_search;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       gt_in;
  logic [3:0] guess;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic [3:0] target;
`ifdef SAR_SEARCH_ABORT_EN
  logic       abort;
`endif

  int checks;
  int failures;

  sar_search #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .gt_in  (gt_in),
`ifdef SAR_SEARCH_ABORT_EN
    .abort  (abort),
`endif
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  assign gt_in = (target > guess);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    target = 4'd0;
`ifdef SAR_SEARCH_ABORT_EN
    abort  = 1'b0;
`endif
    #1;
    checks++;
    if (guess !== 4'd0 || result !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset: guess=%0d result=%0d busy=%b done=%b, required all 0",
               guess, result, busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // exp packs the four expected guesses, MSB-trial guess in the top nibble.
  task automatic test_directed(input string name, input logic [3:0] t,
                               input logic [15:0] exp, input logic [3:0] exp_res);
    target = t;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (guess !== exp[15-4*i -: 4] || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s cycle %0d: guess=%0d busy=%b done=%b, required guess=%0d busy=1 done=0",
                 name, i + 1, guess, busy, done, exp[15-4*i -: 4]);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || result !== exp_res) begin
      failures++;
      $display("FAIL %s done cycle: done=%b busy=%b result=%0d, required done=1 busy=0 result=%0d",
               name, done, busy, result, exp_res);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
      failures++;
      $display("FAIL %s after done: done=%b busy=%b result=%0d, required done=0 busy=0 result=%0d",
               name, done, busy, result, exp_res);
    end
  endtask

  task automatic test_reset_mid();
    target = 4'd12;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (guess !== 4'd0 || result !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: guess=%0d result=%0d busy=%b done=%b, required all 0",
               guess, result, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid idle: busy=%b done=%b, required 0 0", busy, done);
    end
    test_directed("after_reset_t5", 4'd5, {4'd7, 4'd3, 4'd5, 4'd4}, 4'd5);
  endtask

  task automatic test_start_held();
    logic exp_busy;
    logic exp_done;
    target = 4'd6;
    start  = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      exp_busy = ((c % 6) >= 1) && ((c % 6) <= 4);
      exp_done = ((c % 6) == 5);
      checks++;
      if (busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("FAIL start_held cycle %0d: busy=%b done=%b, required busy=%b done=%b",
                 c, busy, done, exp_busy, exp_done);
      end
      if (exp_done) begin
        checks++;
        if (result !== 4'd6) begin
          failures++;
          $display("FAIL start_held result cycle %0d: got %0d, required 6", c, result);
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_held release: busy=%b, required 0", busy);
    end
  endtask

`ifdef SAR_SEARCH_ABORT_EN
  task automatic test_abort();
    test_directed("abort_prep_t9", 4'd9, {4'd7, 4'd11, 4'd9, 4'd8}, 4'd9);
    target = 4'd4;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 4'd9) begin
        failures++;
        $display("FAIL abort cycle %0d: busy=%b done=%b result=%0d, required 0 0 9",
                 i, busy, done, result);
      end
      @(negedge clk);
    end
    abort  = 1'b1;
    start  = 1'b1;
    target = 4'd6;
    @(negedge clk);
    abort  = 1'b0;
    start  = 1'b0;
    checks++;
    if (busy !== 1'b1 || guess !== 4'd7) begin
      failures++;
      $display("FAIL abort_idle_start: busy=%b guess=%0d, required busy=1 guess=7", busy, guess);
    end
    for (int i = 0; i < 5; i++) @(negedge clk);
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed("t9",  4'd9,  {4'd7, 4'd11, 4'd9,  4'd8},  4'd9);
    test_directed("t0",  4'd0,  {4'd7, 4'd3,  4'd1,  4'd0},  4'd0);
    test_directed("t15", 4'd15, {4'd7, 4'd11, 4'd13, 4'd14}, 4'd15);
    test_reset_mid();
    test_start_held();
`ifdef SAR_SEARCH_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search engine, the inverse of the ALU's magnitude comparator. The comparator turns two operands into a relation flag. This block turns a sequence of relation flags back into an unknown operand. It drives a trial value into an external greater-than comparator whose other input is a hidden target, then binary-searches one bit per cycle until it recovers the target. It sits in the ALU comparison group and serves as a self-test/readback aid for the comparator path.

## Interface
- WIDTH, 4, operand width in bits; the search takes WIDTH cycles.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new search; sampled only in IDLE.
- gt_in  input  1  external comparator flag: 1 when target > guess.
- guess  output  WIDTH  registered trial value presented to the comparator.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse when result is valid and newly updated.
- result  output  WIDTH  recovered target; holds until the next completed search.
- abort  input  1  present only with SAR_SEARCH_ABORT_EN.

## Operation
- States:
  - IDLE: waits for start.
  - SEARCH: resolves one bit per cycle, MSB first.
  - DONE: holds for one cycle.
- Internal registers:
  - acc: WIDTH-bit accumulator.
  - idx: bit index, $clog2(WIDTH) bits.
- IDLE to SEARCH on start=1:
  - acc <= 0, idx <= WIDTH-1.
  - guess <= (1<<(WIDTH-1)) - 1.
- Each SEARCH edge:
  - trial = acc | (1<<idx).
  - If gt_in=1 (target >= trial), acc bit idx is set.
  - Then idx decrements and guess <= (new_acc | (1<<(idx-1))) - 1.
- Arithmetic is WIDTH bits, unsigned. trial >= 1 always, so trial-1 never underflows. No value wider than WIDTH is needed.
- SEARCH to DONE on the edge that resolves idx=0:
  - result <= final acc.
  - guess holds its last value.
- DONE to IDLE unconditionally on the next edge.
- start in SEARCH or DONE is ignored and is not queued. If start is held high, a new search begins at the first edge seen in IDLE.
- Reset values: state IDLE, guess 0, result 0, busy 0, done 0, acc 0, idx 0.

## Timing
- Start accepted at edge E0.
- guess for the MSB is valid during cycle 1.
- gt_in is sampled at edges E1..EWIDTH. gt_in must be a combinational function of guess and settle within the cycle.
- busy is high during cycles 1..WIDTH.
- done and the updated result are seen in cycle WIDTH+1 (after edge EWIDTH).
- IDLE resumes at edge E(WIDTH+1). The earliest next start is accepted at E(WIDTH+2).
- Throughput: one search per WIDTH+2 cycles.
- Reset mid-search takes effect immediately (asynchronous). All outputs go to reset values and no done is produced. result is cleared to 0.

## Configuration
- SAR_SEARCH_ABORT_EN defined:
  - The abort port exists.
  - abort=1 at an edge in SEARCH or DONE forces IDLE at that edge. busy drops, done is not asserted (or is cleared if in DONE), and result keeps its prior value.
  - abort has priority over the SEARCH-to-DONE transition.
  - abort is ignored in IDLE, even together with start. In that case start is accepted.
- Undefined: no abort port. Every accepted search runs to DONE.

## Structure
- Shared package sar_search_pkg:
  - state typedef enum {IDLE, SEARCH, DONE}.
  - Default width constant SAR_WIDTH = 4.
- No sub-module in the RTL; a single always_ff plus next-guess logic.
- The bench closes the loop with the team's 4-bit greater-than comparator as the target oracle (x=target, y=guess).

## Test plan
- Target 9, pulse start → guess sequence 7, 11, 9, 8 with gt_in 1, 0, 0, 1 → done in cycle 5, result 9, busy high cycles 1-4.
- Target 0 → guesses 7, 3, 1, 0 with gt_in all 0 → result 0, done single-cycle.
- Target 15 → guesses 7, 11, 13, 14 with gt_in all 1 → result 15.
- rst_n low during cycle 2 of a search for target 12 → guess/result/busy/done 0 immediately. After release, start with target 5 → result 5.
- start held high continuously, target 6 → done pulses every 6 cycles with result 6. start during busy is never accepted early.
- With SAR_SEARCH_ABORT_EN, previous result 9, abort during cycle 3 of a search for target 4 → IDLE next edge, no done, result stays 9.
